row_max_scheduler: RTL
======================

Name: row_max_scheduler

Overview:
- Sequences the score stream from the QK dot-product stage into the running-max stage for one attention tile.
- Tracks key/row position and supplies the previous-max operand for each score: the most-negative value on the first key of a row, otherwise the fed-back running max.
- Holds issue while a max result is outstanding, so the max stage never consumes a stale m_prev.
- Reports each row's final maximum and signals tile completion.

Parameters:
- DATA_W, 16: signed two's-complement width of scores and maxima.
- MAX_SEQ_LENGTH, 64: maximum keys per row and maximum rows per tile.
- CNT_W, $clog2(MAX_SEQ_LENGTH)+1: width of the config and counter fields.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- start  in  1  begin a tile; sampled only in IDLE.
- cfg_num_keys  in  CNT_W  keys per row; legal 0..MAX_SEQ_LENGTH.
- cfg_num_rows  in  CNT_W  rows per tile; legal 0..MAX_SEQ_LENGTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the tile completes.
- s_vld_in  in  1  upstream score valid.
- s_rdy_out  out  1  upstream ready.
- s_in  in  DATA_W  upstream score.
- mx_vld_out  out  1  issue valid to the max stage.
- mx_rdy_in  in  1  max stage ready.
- mx_s_out  out  DATA_W  score to the max stage.
- mx_m_prev_out  out  DATA_W  previous max to the max stage.
- m_fb_vld_in  in  1  max stage output handshake (its vld_out && downstream rdy).
- m_fb_in  in  DATA_W  max stage m_out.
- row_max_vld  out  1  one-cycle pulse carrying the final max of a row.
- row_max  out  DATA_W  final row max.
- row_idx  out  CNT_W  index of the reported row.

Behaviour:
- Reset (reset==0):
  - state=IDLE; all counters 0; running_max=-2^(DATA_W-1); outstanding=0.
  - Outputs busy, done, s_rdy_out, mx_vld_out, row_max_vld = 0; row_max=0; row_idx=0.
- States: IDLE, ISSUE, WAIT_FB, FLUSH.
- IDLE:
  - start=1 latches cfg_num_keys and cfg_num_rows, clears key_cnt and row_cnt.
  - Next state is ISSUE, or FLUSH if either cfg value is 0.
  - start in any other state is ignored.
- ISSUE (pass-through handshake):
  - mx_vld_out = s_vld_in; s_rdy_out = mx_rdy_in; mx_s_out = s_in.
  - mx_m_prev_out = -2^(DATA_W-1) when key_cnt==0, else running_max.
  - On transfer (s_vld_in && mx_rdy_in): outstanding<=1, state<=WAIT_FB. No other state advances.
- WAIT_FB:
  - s_rdy_out=0 and mx_vld_out=0, so at most one score is in flight.
  - On m_fb_vld_in: running_max<=m_fb_in; outstanding<=0; key_cnt<=key_cnt+1.
  - If key_cnt+1 < num_keys: back to ISSUE.
  - If this was the row's last key:
    - Next cycle: row_max_vld=1 with row_max=m_fb_in and row_idx=row_cnt.
    - key_cnt<=0; row_cnt<=row_cnt+1.
    - Next state is ISSUE if rows remain, else FLUSH.
- FLUSH: done=1 for exactly one cycle, then IDLE; busy=0 in the same cycle done is high.
- Ignored feedback: m_fb_vld_in outside WAIT_FB is ignored; the bench flags it as a protocol error.
- Compare semantics: the scheduler does not compare; it relies on the max stage's signed compare. The first-key operand is the signed minimum, never 0.
- Latency and throughput:
  - Issue-to-next-issue is at least 2 cycles, i.e. one max-stage latency plus feedback; throughput is 1 score per (max-stage latency + 1) cycles.
  - row_max_vld occurs 1 cycle after the last feedback.
- Reset mid-tile aborts immediately to the reset values. No done and no row_max_vld are emitted for the aborted tile.
- Width rule: counters compare against latched config at CNT_W bits, so num_keys=MAX_SEQ_LENGTH does not wrap.

Test Plan:
- Basic tile: num_keys=3, num_rows=1, scores 5,-2,9, max stage always ready → m_prev sequence MIN,5,5; row_max_vld once with row_max=9, row_idx=0; done pulse 1 cycle later.
- All-negative row: scores -7,-3,-12 → first m_prev=0x8000 (DATA_W=16); row_max=-3 (checks that first-key m_prev is the signed minimum, not 0).
- Multi-row: num_keys=2, num_rows=3 → 3 row_max_vld pulses with row_idx 0,1,2; m_prev=MIN on the first key of each row; exactly one done.
- Backpressure: mx_rdy_in low 4 cycles with s_vld_in high → s_rdy_out=0 and no state change; feedback withheld 3 cycles → s_rdy_out stays 0 and no second issue.
- Zero config: start with num_keys=0 → no issue, no row_max_vld, done pulse 2 cycles after start; start while busy is ignored.
- Reset mid-row: assert reset (0) after 2 of 4 keys → busy=0, no done; a new start with num_keys=1 produces m_prev=MIN.

Source files
------------

// File: rtl/row_max_scheduler.sv
// rtl/row_max_scheduler.sv - sequences QK scores into the running-max stage for one attention tile
module row_max_scheduler #(
  parameter int DATA_W         = 16,
  parameter int MAX_SEQ_LENGTH = 64,
  parameter int CNT_W          = $clog2(MAX_SEQ_LENGTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_keys,
  input  logic [CNT_W-1:0]  cfg_num_rows,
  output logic              busy,
  output logic              done,
  input  logic              s_vld_in,
  output logic              s_rdy_out,
  input  logic [DATA_W-1:0] s_in,
  output logic              mx_vld_out,
  input  logic              mx_rdy_in,
  output logic [DATA_W-1:0] mx_s_out,
  output logic [DATA_W-1:0] mx_m_prev_out,
  input  logic              m_fb_vld_in,
  input  logic [DATA_W-1:0] m_fb_in,
  output logic              row_max_vld,
  output logic [DATA_W-1:0] row_max,
  output logic [CNT_W-1:0]  row_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FB, FLUSH} state_t;

  // Signed minimum: the neutral operand for a max, so the first key of a row always wins.
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  num_keys, num_rows;
  logic [CNT_W-1:0]  key_cnt, row_cnt;
  logic [CNT_W-1:0]  key_cnt_inc, row_cnt_inc;
  logic [DATA_W-1:0] running_max;
  logic              outstanding;
  logic              issue_xfer, fb_take, last_key, last_row;

  // Counters are CNT_W wide so a count equal to MAX_SEQ_LENGTH compares without wrapping.
  assign key_cnt_inc = key_cnt + CNT_W'(1);
  assign row_cnt_inc = row_cnt + CNT_W'(1);
  assign last_key    = !(key_cnt_inc < num_keys);
  assign last_row    = !(row_cnt_inc < num_rows);
  assign issue_xfer  = (state == ISSUE) && s_vld_in && mx_rdy_in;
  assign fb_take     = (state == WAIT_FB) && outstanding && m_fb_vld_in;

  assign mx_s_out      = s_in;
  assign mx_m_prev_out = (key_cnt == '0) ? MIN_VAL : running_max;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; ISSUE is a pure pass-through, WAIT_FB blocks both sides.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    s_rdy_out  = 1'b0;
    mx_vld_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ((cfg_num_keys == '0) || (cfg_num_rows == '0)) ? FLUSH : ISSUE;
        end
      end
      ISSUE: begin
        mx_vld_out = s_vld_in;
        s_rdy_out  = mx_rdy_in;
        if (issue_xfer) state_nxt = WAIT_FB;
      end
      WAIT_FB: begin
        if (fb_take) begin
          if (!last_key || !last_row) state_nxt = ISSUE;
          else                        state_nxt = FLUSH;
        end
      end
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, key/row tracking, running max feedback and registered row/done reporting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      num_keys    <= '0;
      num_rows    <= '0;
      key_cnt     <= '0;
      row_cnt     <= '0;
      running_max <= MIN_VAL;
      outstanding <= 1'b0;
      done        <= 1'b0;
      row_max_vld <= 1'b0;
      row_max     <= '0;
      row_idx     <= '0;
    end else begin
      done        <= (state == FLUSH);
      row_max_vld <= 1'b0;
      if ((state == IDLE) && start) begin
        num_keys <= cfg_num_keys;
        num_rows <= cfg_num_rows;
        key_cnt  <= '0;
        row_cnt  <= '0;
      end
      if (issue_xfer) outstanding <= 1'b1;
      if (fb_take) begin
        running_max <= m_fb_in;
        outstanding <= 1'b0;
        if (last_key) begin
          key_cnt     <= '0;
          row_cnt     <= row_cnt_inc;
          row_max_vld <= 1'b1;
          row_max     <= m_fb_in;
          row_idx     <= row_cnt;
        end else begin
          key_cnt <= key_cnt_inc;
        end
      end
    end
  end

endmodule
